// File: rtl/ahb_timer_slave_pkg.sv
// Shared AHB-Lite transfer encodings and timer register map.
package ahb_timer_slave_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } transfer_kind_e;

  typedef enum logic [1:0] {
    SIZE_8  = 2'b00,
    SIZE_16 = 2'b01,
    SIZE_32 = 2'b10,
    SIZE_64 = 2'b11
  } transfer_size_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } transfer_response_e;

  localparam logic [1:0] HSIZE_32 = SIZE_32;

  // Byte offsets within the 32-byte timer window.
  localparam logic [4:0] TIMER_REG_CTRL     = 5'h00;
  localparam logic [4:0] TIMER_REG_PRESCALE = 5'h04;
  localparam logic [4:0] TIMER_REG_COUNT_LO = 5'h08;
  localparam logic [4:0] TIMER_REG_COUNT_HI = 5'h0C;
  localparam logic [4:0] TIMER_REG_CMP_LO   = 5'h10;
  localparam logic [4:0] TIMER_REG_CMP_HI   = 5'h14;
  localparam logic [4:0] TIMER_REG_STATUS   = 5'h18;
  localparam logic [4:0] TIMER_REG_INVALID  = 5'h1C;

  typedef struct packed {
    logic auto_reload;
    logic irq_en;
    logic en;
  } timer_ctrl_t;

  // Response sequencing of the slave data phase.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } resp_state_e;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return (trans == TRANS_NONSEQ) || (trans == TRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_frontend.sv
// Reusable AHB-Lite slave front end: address-phase capture, response FSM
// and ready/resp generation. Hands a simple register strobe interface on.
module ahb_slave_frontend
  import ahb_timer_slave_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        hwrite,
  input  logic [4:0]  haddr,
  input  logic [1:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic        hready_in,
  input  logic [31:0] hwdata,
  output logic        hready_out,
  output logic        hresp,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [4:0]  reg_offset,
  output logic [31:0] wdata
);

  resp_state_e state_q, state_d;
  logic [4:0]  offset_q, offset_d;
  logic        write_q, write_d;
  logic        hready_q, hready_d;
  logic        hresp_q, hresp_d;
  logic        accept;
  logic        bad_xfer;

  // Next-state and registered-output computation; ERR1 blocks new acceptance.
  always_comb begin
    accept   = sel && hready_in && is_active_trans(htrans) && (state_q != ST_ERR1);
    bad_xfer = (haddr == TIMER_REG_INVALID) || (haddr[1:0] != 2'b00) || (hsize != HSIZE_32);
    offset_d = offset_q;
    write_d  = write_q;
    if (accept) begin
      offset_d = haddr;
      write_d  = hwrite;
    end
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (accept) begin
      state_d = bad_xfer ? ST_ERR1 : ST_DATA;
    end else begin
      state_d = ST_IDLE;
    end
    hready_d = (state_d != ST_ERR1);
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  end

  // Response FSM with outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      offset_q <= 5'd0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      write_q  <= write_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  assign hready_out = hready_q;
  assign hresp      = hresp_q;
  assign reg_wr     = (state_q == ST_DATA) && write_q;
  assign reg_rd     = (state_q == ST_DATA) && !write_q;
  assign reg_offset = offset_q;
  assign wdata      = hwdata;

endmodule

// File: rtl/ahb_timer_slave.sv
// AHB-Lite timer peripheral: 64-bit prescaled up-counter with compare,
// sticky match flag and level interrupt.
module ahb_timer_slave
  import ahb_timer_slave_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16,
  parameter int RESET_PRESCALE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [1:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic        hready_in,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready_out,
  output logic        hresp,
  output logic        irq
);

  logic        reg_wr, reg_rd;
  logic [4:0]  reg_offset;
  logic [31:0] wdata;
  logic        unused_haddr_hi;

  assign unused_haddr_hi = ^haddr[31:5];

  ahb_slave_frontend u_frontend (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .hwrite     (hwrite),
    .haddr      (haddr[4:0]),
    .hsize      (hsize),
    .htrans     (htrans),
    .hready_in  (hready_in),
    .hwdata     (hwdata),
    .hready_out (hready_out),
    .hresp      (hresp),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_offset (reg_offset),
    .wdata      (wdata)
  );

  timer_ctrl_t               ctrl_q, ctrl_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [63:0]               count_q, count_d;
  logic [63:0]               cmp_q, cmp_d;
  logic                      pending_q, pending_d;
  logic                      irq_q, irq_d;
  logic [63:0]               count_inc;
  logic                      tick, match;
  logic                      wr_ctrl, wr_pre, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi, wr_status;

  // Register writes, prescaler and counter update; bus writes to COUNT
  // override the increment, a match set beats a STATUS clear.
  always_comb begin
    wr_ctrl   = reg_wr && (reg_offset == TIMER_REG_CTRL);
    wr_pre    = reg_wr && (reg_offset == TIMER_REG_PRESCALE);
    wr_cnt_lo = reg_wr && (reg_offset == TIMER_REG_COUNT_LO);
    wr_cnt_hi = reg_wr && (reg_offset == TIMER_REG_COUNT_HI);
    wr_cmp_lo = reg_wr && (reg_offset == TIMER_REG_CMP_LO);
    wr_cmp_hi = reg_wr && (reg_offset == TIMER_REG_CMP_HI);
    wr_status = reg_wr && (reg_offset == TIMER_REG_STATUS);

    tick      = ctrl_q.en && (pcnt_q == prescale_q);
    count_inc = count_q + 64'd1;
    match     = tick && (count_inc == cmp_q) && !(wr_cnt_lo || wr_cnt_hi);

    ctrl_d     = wr_ctrl ? timer_ctrl_t'(wdata[2:0]) : ctrl_q;
    prescale_d = wr_pre ? wdata[PRESCALE_WIDTH-1:0] : prescale_q;

    pcnt_d = pcnt_q;
    if (wr_pre) begin
      pcnt_d = '0;
    end else if (ctrl_q.en) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESCALE_WIDTH'(1);
    end

    count_d = count_q;
    if (tick) begin
      count_d = (match && ctrl_q.auto_reload) ? 64'd0 : count_inc;
    end
    if (wr_cnt_lo) count_d = {count_q[63:32], wdata};
    if (wr_cnt_hi) count_d = {wdata, count_q[31:0]};

    cmp_d = cmp_q;
    if (wr_cmp_lo) cmp_d[31:0]  = wdata;
    if (wr_cmp_hi) cmp_d[63:32] = wdata;

    pending_d = pending_q;
    if (wr_status && wdata[0]) pending_d = 1'b0;
    if (match) pending_d = 1'b1;

    irq_d = pending_q && ctrl_q.irq_en;
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= '0;
      prescale_q <= PRESCALE_WIDTH'(RESET_PRESCALE);
      pcnt_q     <= '0;
      count_q    <= 64'd0;
      cmp_q      <= '1;
      pending_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
    end
  end

  // Read data is driven only during a read data phase, from the latched offset.
  always_comb begin
    hrdata = 32'd0;
    if (reg_rd) begin
      case (reg_offset)
        TIMER_REG_CTRL:     hrdata = {29'd0, ctrl_q};
        TIMER_REG_PRESCALE: hrdata = 32'(prescale_q);
        TIMER_REG_COUNT_LO: hrdata = count_q[31:0];
        TIMER_REG_COUNT_HI: hrdata = count_q[63:32];
        TIMER_REG_CMP_LO:   hrdata = cmp_q[31:0];
        TIMER_REG_CMP_HI:   hrdata = cmp_q[63:32];
        TIMER_REG_STATUS:   hrdata = {31'd0, pending_q};
        default:            hrdata = 32'd0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Self-checking bench for ahb_timer_slave: cycle model of the register
// rules checked every cycle, plus directed literal expectations.
module tb_ahb_timer_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic [1:0]  hsize = 2'd2;
  logic [1:0]  htrans = 2'd0;
  logic        hready_in = 1'b1;
  logic [31:0] hwdata = 32'd0;
  logic [31:0] hrdata;
  logic        hready_out;
  logic        hresp;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic cmp_on = 1'b0;

  ahb_timer_slave #(.PRESCALE_WIDTH(16), .RESET_PRESCALE(0)) dut (
    .clk(clk), .rst(rst), .sel(sel), .hwrite(hwrite), .haddr(haddr),
    .hsize(hsize), .htrans(htrans), .hready_in(hready_in), .hwdata(hwdata),
    .hrdata(hrdata), .hready_out(hready_out), .hresp(hresp), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_en, m_ie, m_ar;
  logic [15:0] m_pre, m_pdiv;
  logic [63:0] m_count, m_cmp;
  logic        m_pend, m_irq;
  int          m_phase;        // 0 none, 1 data phase, 2 first error cycle, 3 second error cycle
  logic [4:0]  m_off;
  logic        m_wr;

  function automatic logic [31:0] mreg(input logic [4:0] off);
    case (off)
      5'h00: return {29'd0, m_ar, m_ie, m_en};
      5'h04: return {16'd0, m_pre};
      5'h08: return m_count[31:0];
      5'h0C: return m_count[63:32];
      5'h10: return m_cmp[31:0];
      5'h14: return m_cmp[63:32];
      5'h18: return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic        tick, match, acc, bad, commit, npend;
    logic [63:0] nc;
    logic [15:0] np;
    if (!rst) begin
      m_en <= 0; m_ie <= 0; m_ar <= 0;
      m_pre <= 16'd0; m_pdiv <= 16'd0;
      m_count <= 64'd0; m_cmp <= {64{1'b1}};
      m_pend <= 0; m_irq <= 0;
      m_phase <= 0; m_off <= 5'd0; m_wr <= 0;
    end else begin
      commit = (m_phase == 1) && m_wr;
      tick   = m_en && (m_pdiv == m_pre);
      np     = m_en ? (tick ? 16'd0 : m_pdiv + 16'd1) : m_pdiv;
      nc     = m_count;
      match  = 1'b0;
      if (tick) begin
        nc = m_count + 64'd1;
        if (nc == m_cmp) begin
          match = 1'b1;
          if (m_ar) nc = 64'd0;
        end
      end
      npend = m_pend;
      m_irq <= m_pend && m_ie;
      if (commit) begin
        case (m_off)
          5'h00: {m_ar, m_ie, m_en} <= hwdata[2:0];
          5'h04: begin m_pre <= hwdata[15:0]; np = 16'd0; end
          5'h08: begin nc = {m_count[63:32], hwdata}; match = 1'b0; end
          5'h0C: begin nc = {hwdata, m_count[31:0]}; match = 1'b0; end
          5'h10: m_cmp[31:0] <= hwdata;
          5'h14: m_cmp[63:32] <= hwdata;
          5'h18: if (hwdata[0]) npend = 1'b0;
          default: ;
        endcase
      end
      if (match) npend = 1'b1;
      m_count <= nc;
      m_pdiv  <= np;
      m_pend  <= npend;
      acc = sel && hready_in && htrans[1] && (m_phase != 2);
      bad = (haddr[4:0] == 5'h1C) || (haddr[1:0] != 2'b00) || (hsize != 2'd2);
      if (m_phase == 2)  m_phase <= 3;
      else if (acc)      m_phase <= bad ? 2 : 1;
      else               m_phase <= 0;
      if (acc) begin
        m_off <= haddr[4:0];
        m_wr  <= hwrite;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("hready_out", {63'd0, hready_out}, {63'd0, m_phase != 2});
      chk("hresp", {63'd0, hresp}, {63'd0, m_phase >= 2});
      chk("hrdata", {32'd0, hrdata}, {32'd0, (m_phase == 1 && !m_wr) ? mreg(m_off) : 32'd0});
      chk("irq", {63'd0, irq}, {63'd0, m_irq});
    end
  end

  // ---------------- bus tasks ----------------
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic first_ready, output logic first_resp, output logic last_resp);
    int n;
    @(posedge clk); #1;
    sel = 1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    @(posedge clk); #1;
    sel = 0; htrans = 2'b00; hwdata = wd;
    @(negedge clk);
    first_ready = hready_out; first_resp = hresp; rd = hrdata;
    n = 0;
    while (!hready_out && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (!hready_out) chk("xfer_timeout", {63'd0, hready_out}, 64'd1);
    last_resp = hresp;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic fr, fresp, lresp;
    xfer(1'b1, addr, 2'd2, wd, rd, fr, fresp, lresp);
    chk("wr_zero_wait", {63'd0, fr}, 64'd1);
    chk("wr_okay", {63'd0, fresp}, 64'd0);
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] rd);
    logic fr, fresp, lresp;
    xfer(1'b0, addr, 2'd2, 32'd0, rd, fr, fresp, lresp);
    chk("rd_zero_wait", {63'd0, fr}, 64'd1);
    chk("rd_okay", {63'd0, fresp}, 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic fr, fresp, lresp;

    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_hready", {63'd0, hready_out}, 64'd1);
    chk("reset_hresp", {63'd0, hresp}, 64'd0);
    chk("reset_irq", {63'd0, irq}, 64'd0);
    chk("reset_hrdata", {32'd0, hrdata}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Compare register resets to all ones
    bus_rd(32'h10, rd); chk("cmp_lo_reset", {32'd0, rd}, 64'hFFFF_FFFF);
    bus_rd(32'h14, rd); chk("cmp_hi_reset", {32'd0, rd}, 64'hFFFF_FFFF);
    chk("irq_idle", {63'd0, irq}, 64'd0);

    // IDLE and BUSY with sel high must not start a data phase
    @(posedge clk); #1 sel = 1; htrans = 2'b00; haddr = 32'h1C;
    @(posedge clk); #1 htrans = 2'b01;
    @(posedge clk); #1 sel = 0; htrans = 2'b00;

    // Prescale 3: one increment every 4 enabled cycles, 40 cycles -> 10
    bus_wr(32'h04, 32'd3);
    bus_wr(32'h00, 32'h1);
    idle(38);
    bus_wr(32'h00, 32'h0);
    bus_rd(32'h08, rd); chk("count_after_40", {32'd0, rd}, 64'd10);

    // Compare 5 with auto reload at full speed
    bus_wr(32'h04, 32'd0);
    bus_wr(32'h08, 32'd0);
    bus_wr(32'h0C, 32'd0);
    bus_wr(32'h10, 32'd5);
    bus_wr(32'h14, 32'd0);
    bus_wr(32'h00, 32'h7);
    idle(12);
    bus_rd(32'h18, rd); chk("pending_set", {32'd0, rd}, 64'd1);
    chk("irq_set", {63'd0, irq}, 64'd1);
    bus_rd(32'h08, rd); chk("count_below_cmp", {63'd0, rd < 32'd5}, 64'd1);
    bus_wr(32'h00, 32'h6);
    bus_wr(32'h18, 32'h1);
    idle(2);
    @(negedge clk);
    chk("irq_cleared", {63'd0, irq}, 64'd0);
    bus_rd(32'h18, rd); chk("pending_cleared", {32'd0, rd}, 64'd0);

    // Error responses: invalid offset, misaligned, wrong size
    xfer(1'b0, 32'h1C, 2'd2, 32'd0, rd, fr, fresp, lresp);
    chk("err_inv_ready1", {63'd0, fr}, 64'd0);
    chk("err_inv_resp1", {63'd0, fresp}, 64'd1);
    chk("err_inv_resp2", {63'd0, lresp}, 64'd1);
    xfer(1'b1, 32'h02, 2'd2, 32'hFF, rd, fr, fresp, lresp);
    chk("err_mis_ready1", {63'd0, fr}, 64'd0);
    chk("err_mis_resp2", {63'd0, lresp}, 64'd1);
    xfer(1'b1, 32'h00, 2'd0, 32'h1, rd, fr, fresp, lresp);
    chk("err_size_resp1", {63'd0, fresp}, 64'd1);
    bus_rd(32'h00, rd); chk("ctrl_unchanged", {32'd0, rd}, 64'h6);

    // 64-bit wrap
    bus_wr(32'h00, 32'h0);
    bus_wr(32'h14, 32'h1234_5678);
    bus_wr(32'h0C, 32'hFFFF_FFFF);
    bus_wr(32'h08, 32'hFFFF_FFFE);
    bus_wr(32'h00, 32'h1);
    bus_wr(32'h00, 32'h0);
    bus_rd(32'h08, rd); chk("wrap_lo", {32'd0, rd}, 64'd0);
    bus_rd(32'h0C, rd); chk("wrap_hi", {32'd0, rd}, 64'd0);

    // Write to COUNT_LO while counting
    bus_wr(32'h00, 32'h1);
    bus_wr(32'h08, 32'hABCD_0000);
    bus_wr(32'h00, 32'h0);
    bus_rd(32'h08, rd); chk("count_wr_lo", {32'd0, rd}, 64'hABCD_0002);
    bus_rd(32'h0C, rd); chk("count_wr_hi", {32'd0, rd}, 64'd0);

    // Back-to-back write CTRL then read CTRL
    @(posedge clk); #1 sel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h00; hsize = 2'd2;
    @(posedge clk); #1 hwdata = 32'h2; htrans = 2'b10; hwrite = 0; haddr = 32'h00;
    @(negedge clk);
    chk("b2b_wr_ready", {63'd0, hready_out}, 64'd1);
    @(posedge clk); #1 sel = 0; htrans = 2'b00;
    @(negedge clk);
    chk("b2b_rd_ready", {63'd0, hready_out}, 64'd1);
    chk("b2b_rd_data", {32'd0, hrdata}, 64'h2);

    // Reset during a data phase
    @(posedge clk); #1 sel = 1; htrans = 2'b10; hwrite = 0; haddr = 32'h00;
    @(posedge clk); #1 sel = 0; htrans = 2'b00;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ready", {63'd0, hready_out}, 64'd1);
    chk("rst_mid_resp", {63'd0, hresp}, 64'd0);
    chk("rst_mid_rdata", {32'd0, hrdata}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    bus_rd(32'h00, rd); chk("ctrl_after_rst", {32'd0, rd}, 64'd0);

    idle(2);
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
